// File: rtl/instruction_sequencer.sv
// Program-driven requester for one datapath router port: issues a stored
// instruction list over start/finished for a number of passes and sums the results.
module instruction_sequencer #(
  parameter int IW      = 32,
  parameter int RW      = 32,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          run,
  input  logic [AW:0]   prog_len,
  input  logic [7:0]    passes,
  input  logic          abort,
  output logic [IW-1:0] instruction,
  output logic          start,
  input  logic [RW-1:0] result,
  input  logic          finished,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [7:0]    pass_cnt,
  output logic [RW-1:0] result_out,
  output logic          result_valid,
  output logic [RW-1:0] acc
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERROR} state_t;
  state_t state, state_next;

  logic [IW-1:0] mem [DEPTH];
  logic [AW:0]   len_q;
  logic [7:0]    passes_q;
  logic [TW-1:0] tmo_cnt;
  logic          first_wait;
  logic          abort_pending;

  logic          can_run;
  logic          load_ok;
  logic          accept_run;
  logic          fin_ok;
  logic          stop_abort;
  logic          last_instr;
  logic          last_pass;
  logic          tmo_hit;
  logic [AW-1:0] pc_next;
  logic [IW-1:0] fetch_word;

  function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return a + b;
  endfunction

  assign busy  = (state == S_ISSUE) || (state == S_WAIT);
  assign start = (state == S_ISSUE);

  always_comb begin
    can_run    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    load_ok    = load_en && can_run;
    accept_run = run && can_run;
    // The router drops finished only on the edge that samples start, so the
    // first WAIT cycle still shows the previous completion and is skipped.
    fin_ok     = (state == S_WAIT) && !first_wait && finished;
    stop_abort = abort_pending || abort;
    last_instr = ({1'b0, pc} == (len_q - 1'b1));
    last_pass  = ((pass_cnt + 8'd1) == passes_q);
    tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
    state_next = state;
    pc_next    = pc;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (run) begin
          state_next = (prog_len == '0) ? S_DONE : S_ISSUE;
          pc_next    = '0;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (fin_ok) begin
          if (stop_abort) begin
            state_next = S_DONE;
          end else if (last_instr) begin
            pc_next    = '0;
            state_next = last_pass ? S_DONE : S_ISSUE;
          end else begin
            pc_next    = pc + 1'b1;
            state_next = S_ISSUE;
          end
        end else if (tmo_hit) begin
          state_next = S_ERROR;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Write-first: a word loaded in the same cycle as run is what ISSUE sends.
    fetch_word = (load_ok && (load_addr == pc_next)) ? load_data : mem[pc_next];
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (load_ok) mem[load_addr] <= load_data;
    if (accept_run) begin
      len_q    <= prog_len;
      passes_q <= (passes == 8'd0) ? 8'd1 : passes;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      instruction   <= '0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      error         <= 1'b0;
      pc            <= '0;
      pass_cnt      <= '0;
      result_out    <= '0;
      result_valid  <= 1'b0;
      acc           <= '0;
      abort_pending <= 1'b0;
      first_wait    <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      done         <= (state_next == S_DONE) && (accept_run || (state == S_WAIT));
      result_valid <= fin_ok;
      pc           <= pc_next;
      first_wait   <= (state == S_ISSUE);
      tmo_cnt      <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (state_next == S_ISSUE) instruction <= fetch_word;
      if (accept_run) begin
        pass_cnt      <= '0;
        acc           <= '0;
        error         <= 1'b0;
        aborted       <= 1'b0;
        abort_pending <= 1'b0;
      end else begin
        if (busy && abort) abort_pending <= 1'b1;
        if (fin_ok) begin
          result_out <= result;
          acc        <= wrap_add(acc, result);
          if (stop_abort)      aborted  <= 1'b1;
          else if (last_instr) pass_cnt <= pass_cnt + 8'd1;
        end
        if ((state == S_WAIT) && !fin_ok && tmo_hit) error <= 1'b1;
      end
    end
  end
endmodule
